// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path and its arbiter.
// Holds the arbiter state encoding, the baud divider shared with uart_tx,
// and the default requester count and byte timeout.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    START   = 3'd2,
    WAIT_LO = 3'd3,
    WAIT_HI = 3'd4
  } arb_state_t;

  localparam logic [11:0] BAUD_DIV    = 12'hA2B;
  localparam int          NUM_REQ_DEF = 4;
  localparam int          BYTE_TO_DEF = 4096;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side and uart_tx-side signals of the transmit arbiter.
// master: the environment (requesters plus uart_tx tx_done); slave: the arbiter.
// Ports: req/byte_vld/byte_data/byte_last/byte_rdy/gnt to requesters,
//        strt_tx/tx_data/tx_done to uart_tx, busy/msg_done/abort status.
interface uart_tx_arb_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   byte_vld;
  logic [8*NUM_REQ-1:0] byte_data;
  logic [NUM_REQ-1:0]   byte_last;
  logic [NUM_REQ-1:0]   byte_rdy;
  logic [NUM_REQ-1:0]   gnt;
  logic                 strt_tx;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 busy;
  logic                 msg_done;
  logic                 abort;

  modport master (
    output req, byte_vld, byte_data, byte_last, tx_done,
    input  byte_rdy, gnt, strt_tx, tx_data, busy, msg_done, abort
  );

  modport slave (
    input  req, byte_vld, byte_data, byte_last, tx_done,
    output byte_rdy, gnt, strt_tx, tx_data, busy, msg_done, abort
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or above ptr, wrapping past N-1.
// Latency: purely combinational. Backpressure: none, pure function of inputs.
// Ports: req (request vector), ptr (search start), winner (one-hot), any_req.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          any_req
);

  logic found;

  // The modulo makes the wrap explicit, so non-power-of-two N never
  // selects a nonexistent requester.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        winner[(int'(ptr) + i) % N] = 1'b1;
        found                        = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uart_tx between NUM_REQ requesters, a whole message per grant.
// Latency: grant 1 cycle after req; strt_tx 1 cycle after a byte is accepted.
// Backpressure: byte_rdy only to the granted requester while uart_tx is idle.
// Ports: clk, rst_n (async, active-low), bus (uart_tx_arb_if slave modport).
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int BYTE_TO = BYTE_TO_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_arb_if.slave  bus
);

  localparam int            PW       = $clog2(NUM_REQ);
  localparam int            TW       = $clog2(BYTE_TO);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(BYTE_TO - 1);

  arb_state_t           state;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        gidx;
  logic [TW-1:0]        to_cnt;
  logic [7:0]           tx_data_q;
  logic                 strt_q;
  logic                 msg_done_q;
  logic                 abort_q;
  logic                 last_q;
  logic                 wl_cnt;
  logic                 retried;

  logic [NUM_REQ-1:0]   winner;
  logic                 any_req;
  logic [PW-1:0]        win_idx;
  logic [PW-1:0]        ptr_next;
  logic [NUM_REQ-1:0]   byte_rdy_c;
  logic                 sel_req;
  logic                 sel_vld;
  logic                 sel_last;
  logic [7:0]           sel_data;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = PW'(i);
    end
  end

  // Lanes of the currently granted requester.
  always_comb begin
    sel_req    = 1'b0;
    sel_vld    = 1'b0;
    sel_last   = 1'b0;
    sel_data   = 8'h00;
    byte_rdy_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == PW'(i)) begin
        sel_req       = bus.req[i];
        sel_vld       = bus.byte_vld[i];
        sel_last      = bus.byte_last[i];
        sel_data      = bus.byte_data[8*i +: 8];
        byte_rdy_c[i] = (state == GRANT) && bus.req[i] && bus.tx_done;
      end
    end
  end

  // Next search start is the requester just after the one being released.
  assign ptr_next = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_q      <= '0;
      ptr        <= '0;
      gidx       <= '0;
      to_cnt     <= '0;
      tx_data_q  <= 8'h00;
      strt_q     <= 1'b0;
      msg_done_q <= 1'b0;
      abort_q    <= 1'b0;
      last_q     <= 1'b0;
      wl_cnt     <= 1'b0;
      retried    <= 1'b0;
    end else begin
      strt_q     <= 1'b0;
      msg_done_q <= 1'b0;
      abort_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req && bus.tx_done) begin
            gnt_q  <= winner;
            gidx   <= win_idx;
            to_cnt <= '0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          // A dropped request beats a byte offered in the same cycle.
          if (!sel_req) begin
            gnt_q   <= '0;
            abort_q <= 1'b1;
            ptr     <= ptr_next;
            to_cnt  <= '0;
            state   <= IDLE;
          end else if (sel_vld && bus.tx_done) begin
            tx_data_q <= sel_data;
            last_q    <= sel_last;
            to_cnt    <= '0;
            retried   <= 1'b0;
            strt_q    <= 1'b1;
            state     <= START;
          end else if (to_cnt == TO_MAX) begin
            gnt_q   <= '0;
            abort_q <= 1'b1;
            ptr     <= ptr_next;
            to_cnt  <= '0;
            state   <= IDLE;
          end else begin
            // Release happens at TO_MAX, so this never wraps.
            to_cnt <= to_cnt + 1'b1;
          end
        end
        START: begin
          wl_cnt <= 1'b0;
          state  <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!bus.tx_done) begin
            state <= WAIT_HI;
          end else if (wl_cnt) begin
            // uart_tx ignored the pulse: retry once. If the retry is also
            // ignored, fall through to WAIT_HI (tx_done is already high) so
            // the grant cannot hang on a dead transmitter.
            if (!retried) begin
              retried <= 1'b1;
              strt_q  <= 1'b1;
              state   <= START;
            end else begin
              state <= WAIT_HI;
            end
          end else begin
            wl_cnt <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (bus.tx_done) begin
            if (last_q) begin
              gnt_q      <= '0;
              msg_done_q <= 1'b1;
              ptr        <= ptr_next;
              state      <= IDLE;
            end else begin
              state <= GRANT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.byte_rdy = byte_rdy_c;
  assign bus.strt_tx  = strt_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = (state != IDLE);
  assign bus.msg_done = msg_done_q;
  assign bus.abort    = abort_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a small uart_tx model on tx_done.
// Inputs are driven and outputs sampled on the falling clock edge; an event
// monitor records strt_tx, msg_done, abort and grants with cycle stamps.
module tb_uart_tx_arb;

  localparam int NR    = 4;
  localparam int BTO   = 16;
  localparam int FRAME = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arb #(.NUM_REQ(NR), .BYTE_TO(BTO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: tx_done falls the cycle after strt_tx, stays low FRAME cycles.
  logic stuck = 1'b0;
  int   fcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tx_done <= 1'b1;
      fcnt        <= 0;
    end else if (bus.strt_tx && !stuck && fcnt == 0) begin
      bus.tx_done <= 1'b0;
      fcnt        <= FRAME;
    end else if (fcnt != 0) begin
      fcnt <= fcnt - 1;
      if (fcnt == 1) bus.tx_done <= 1'b1;
    end
  end

  // Event monitor
  logic [7:0]    strt_dat [64];
  int            strt_cyc [64];
  int            md_cyc   [64];
  int            ab_cyc   [64];
  logic [NR-1:0] gnt_seq  [64];
  int            gnt_cyc  [64];
  int            n_strt = 0, n_bad = 0, n_md = 0, n_ab = 0, n_gnt = 0;
  logic [NR-1:0] prev_gnt = '0;

  always @(posedge clk) begin
    #1;
    if (bus.strt_tx) begin
      if (n_strt < 64) begin strt_dat[n_strt] = bus.tx_data; strt_cyc[n_strt] = cyc; end
      n_strt++;
      if (!bus.tx_done) n_bad++;
    end
    if (bus.msg_done) begin
      if (n_md < 64) md_cyc[n_md] = cyc;
      n_md++;
    end
    if (bus.abort) begin
      if (n_ab < 64) ab_cyc[n_ab] = cyc;
      n_ab++;
    end
    if (bus.gnt != prev_gnt && bus.gnt != '0) begin
      if (n_gnt < 64) begin gnt_seq[n_gnt] = bus.gnt; gnt_cyc[n_gnt] = cyc; end
      n_gnt++;
    end
    prev_gnt = bus.gnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Plays requester r sending n bytes; returns once msg_done is seen.
  task automatic send_msg(input int r, input int n, input logic [7:0] d0,
                          input logic [7:0] d1, input logic [7:0] d2, output bit ok);
    int k;
    int md0;
    k   = 0;
    md0 = n_md;
    ok  = 1'b0;
    bus.req[r] = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (n_md > md0) begin ok = 1'b1; break; end
      if (k < n) begin
        bus.byte_vld[r]         = 1'b1;
        bus.byte_last[r]        = (k == n - 1);
        bus.byte_data[8*r +: 8] = (k == 0) ? d0 : ((k == 1) ? d1 : d2);
      end else begin
        bus.byte_vld[r]  = 1'b0;
        bus.byte_last[r] = 1'b0;
      end
      #1;
      if (bus.byte_rdy[r] && bus.byte_vld[r]) k++;
      @(negedge clk);
    end
    bus.req[r]       = 1'b0;
    bus.byte_vld[r]  = 1'b0;
    bus.byte_last[r] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = '1;
    step(); step();
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL rst_gnt got=%b exp=0000", bus.gnt); end
    vectors++; if (bus.strt_tx !== 1'b0) begin miscompares++; $display("FAIL rst_strt got=%b exp=0", bus.strt_tx); end
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data got=%h exp=00", bus.tx_data); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.msg_done !== 1'b0 || bus.abort !== 1'b0) begin miscompares++; $display("FAIL rst_pulses got=%b%b exp=00", bus.msg_done, bus.abort); end
    vectors++; if (bus.byte_rdy !== 4'b0000) begin miscompares++; $display("FAIL rst_byte_rdy got=%b exp=0000", bus.byte_rdy); end
    bus.req = '0;
    step();
    rst_n = 1'b1;
    step(); step();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_rr_order();
    int g0, m0, s0;
    g0 = n_gnt; m0 = n_md; s0 = n_strt;
    bus.byte_data = {8'h43, 8'h42, 8'h41, 8'h40};
    bus.byte_vld  = 4'b1011;
    bus.byte_last = 4'b1011;
    bus.req       = 4'b1011;
    for (int t = 0; t < 300; t++) begin
      if (n_md - m0 >= 4) break;
      step();
    end
    bus.req = '0; bus.byte_vld = '0; bus.byte_last = '0;
    vectors++; if (n_md - m0 != 4) begin miscompares++; $display("FAIL rr_msgs got=%0d exp=4", n_md - m0); end
    vectors++; if (gnt_seq[g0] !== 4'b0001) begin miscompares++; $display("FAIL rr_g0 got=%b exp=0001", gnt_seq[g0]); end
    vectors++; if (gnt_seq[g0+1] !== 4'b0010) begin miscompares++; $display("FAIL rr_g1 got=%b exp=0010", gnt_seq[g0+1]); end
    vectors++; if (gnt_seq[g0+2] !== 4'b1000) begin miscompares++; $display("FAIL rr_g2 got=%b exp=1000", gnt_seq[g0+2]); end
    vectors++; if (gnt_seq[g0+3] !== 4'b0001) begin miscompares++; $display("FAIL rr_g3 got=%b exp=0001", gnt_seq[g0+3]); end
    vectors++; if (strt_dat[s0+2] !== 8'h43) begin miscompares++; $display("FAIL rr_data2 got=%h exp=43", strt_dat[s0+2]); end
    step(); step();
    vectors++; if (n_gnt - g0 != 4) begin miscompares++; $display("FAIL rr_grants got=%0d exp=4", n_gnt - g0); end
  endtask

  task automatic test_single_msg();
    int g0, m0, s0, a0;
    bit ok;
    g0 = n_gnt; m0 = n_md; s0 = n_strt; a0 = n_ab;
    send_msg(1, 3, 8'hA5, 8'h3C, 8'h81, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL msg_timeout got=no_msg_done exp=msg_done"); end
    vectors++; if (gnt_seq[g0] !== 4'b0010) begin miscompares++; $display("FAIL msg_gnt got=%b exp=0010", gnt_seq[g0]); end
    vectors++; if (n_strt - s0 != 3) begin miscompares++; $display("FAIL msg_strt_cnt got=%0d exp=3", n_strt - s0); end
    vectors++; if (strt_dat[s0] !== 8'hA5) begin miscompares++; $display("FAIL msg_b0 got=%h exp=a5", strt_dat[s0]); end
    vectors++; if (strt_dat[s0+1] !== 8'h3C) begin miscompares++; $display("FAIL msg_b1 got=%h exp=3c", strt_dat[s0+1]); end
    vectors++; if (strt_dat[s0+2] !== 8'h81) begin miscompares++; $display("FAIL msg_b2 got=%h exp=81", strt_dat[s0+2]); end
    vectors++; if (strt_cyc[s0] - gnt_cyc[g0] != 1) begin miscompares++; $display("FAIL msg_first_lat got=%0d exp=1", strt_cyc[s0] - gnt_cyc[g0]); end
    vectors++; if (strt_cyc[s0+1] - strt_cyc[s0] != 7) begin miscompares++; $display("FAIL msg_spacing got=%0d exp=7", strt_cyc[s0+1] - strt_cyc[s0]); end
    vectors++; if (md_cyc[m0] - strt_cyc[s0+2] != 6) begin miscompares++; $display("FAIL msg_done_lat got=%0d exp=6", md_cyc[m0] - strt_cyc[s0+2]); end
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL msg_gnt_release got=%b exp=0000", bus.gnt); end
    step(); step();
    vectors++; if (n_md - m0 != 1) begin miscompares++; $display("FAIL msg_done_cnt got=%0d exp=1", n_md - m0); end
    vectors++; if (n_ab - a0 != 0) begin miscompares++; $display("FAIL msg_abort_cnt got=%0d exp=0", n_ab - a0); end
  endtask

  task automatic test_req_drop();
    int g0, s0, a0, m0;
    bit seen;
    g0 = n_gnt; s0 = n_strt; a0 = n_ab; m0 = n_md;
    seen = 1'b0;
    bus.byte_data[23:16] = 8'h77;
    bus.byte_last[2]     = 1'b1;
    bus.req[2]           = 1'b1;
    for (int t = 0; t < 20; t++) begin
      step();
      if (bus.gnt[2]) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL drop_grant_wait got=no_grant exp=gnt[2]"); end
    bus.req[2]      = 1'b0;
    bus.byte_vld[2] = 1'b1;
    #1;
    vectors++; if (bus.byte_rdy !== 4'b0000) begin miscompares++; $display("FAIL drop_byte_rdy got=%b exp=0000", bus.byte_rdy); end
    step();
    vectors++; if (bus.abort !== 1'b1) begin miscompares++; $display("FAIL drop_abort got=%b exp=1", bus.abort); end
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL drop_gnt got=%b exp=0000", bus.gnt); end
    bus.byte_vld[2] = 1'b0;
    step(); step();
    vectors++; if (n_strt - s0 != 0) begin miscompares++; $display("FAIL drop_strt got=%0d exp=0", n_strt - s0); end
    vectors++; if (n_ab - a0 != 1) begin miscompares++; $display("FAIL drop_abort_cnt got=%0d exp=1", n_ab - a0); end
    // ptr now 3: with requesters 2 and 3 both asking, 3 must win.
    bus.byte_data[31:24] = 8'h33;
    bus.byte_data[23:16] = 8'h22;
    bus.byte_vld  = 4'b1100;
    bus.byte_last = 4'b1100;
    bus.req       = 4'b1100;
    for (int t = 0; t < 60; t++) begin
      if (n_md > m0) break;
      step();
    end
    bus.req = '0; bus.byte_vld = '0; bus.byte_last = '0;
    vectors++; if (gnt_seq[g0+1] !== 4'b1000) begin miscompares++; $display("FAIL drop_ptr_gnt got=%b exp=1000", gnt_seq[g0+1]); end
    vectors++; if (strt_dat[s0] !== 8'h33) begin miscompares++; $display("FAIL drop_ptr_data got=%h exp=33", strt_dat[s0]); end
    step(); step();
  endtask

  task automatic test_timeout();
    int g0, s0, a0, m0;
    g0 = n_gnt; s0 = n_strt; a0 = n_ab; m0 = n_md;
    bus.byte_data[23:16] = 8'h5A;
    bus.byte_vld  = 4'b0100;
    bus.byte_last = 4'b0100;
    bus.req       = 4'b0110;
    for (int t = 0; t < 100; t++) begin
      if (n_md > m0) break;
      step();
    end
    bus.req = '0; bus.byte_vld = '0; bus.byte_last = '0;
    vectors++; if (n_md - m0 != 1) begin miscompares++; $display("FAIL to_msg got=%0d exp=1", n_md - m0); end
    vectors++; if (gnt_seq[g0] !== 4'b0010) begin miscompares++; $display("FAIL to_first_gnt got=%b exp=0010", gnt_seq[g0]); end
    vectors++; if (n_ab - a0 != 1) begin miscompares++; $display("FAIL to_abort_cnt got=%0d exp=1", n_ab - a0); end
    vectors++; if (ab_cyc[a0] - gnt_cyc[g0] != 16) begin miscompares++; $display("FAIL to_abort_delay got=%0d exp=16", ab_cyc[a0] - gnt_cyc[g0]); end
    vectors++; if (gnt_seq[g0+1] !== 4'b0100) begin miscompares++; $display("FAIL to_next_gnt got=%b exp=0100", gnt_seq[g0+1]); end
    vectors++; if (gnt_cyc[g0+1] - ab_cyc[a0] != 1) begin miscompares++; $display("FAIL to_regrant_delay got=%0d exp=1", gnt_cyc[g0+1] - ab_cyc[a0]); end
    vectors++; if (n_strt - s0 != 1 || strt_dat[s0] !== 8'h5A) begin miscompares++; $display("FAIL to_next_data got=%0d/%h exp=1/5a", n_strt - s0, strt_dat[s0]); end
    step(); step();
  endtask

  task automatic test_reset_mid();
    int s0, m0, a0, g0;
    bit seen, ok;
    s0 = n_strt; m0 = n_md; a0 = n_ab; g0 = n_gnt;
    seen = 1'b0;
    bus.byte_data[7:0] = 8'hC3;
    bus.byte_last[0]   = 1'b0;
    bus.byte_vld[0]    = 1'b1;
    bus.req[0]         = 1'b1;
    for (int t = 0; t < 20; t++) begin
      step();
      if (n_strt > s0) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL mid_strt_wait got=no_strt exp=strt"); end
    step(); step();
    vectors++; if (bus.busy !== 1'b1 || bus.tx_data !== 8'hC3) begin miscompares++; $display("FAIL mid_pre busy/data got=%b/%h exp=1/c3", bus.busy, bus.tx_data); end
    rst_n   = 1'b0;
    bus.req = '0; bus.byte_vld = '0;
    #1;
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL mid_gnt got=%b exp=0000", bus.gnt); end
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL mid_tx_data got=%h exp=00", bus.tx_data); end
    vectors++; if (bus.strt_tx !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_strt_busy got=%b/%b exp=0/0", bus.strt_tx, bus.busy); end
    step(); step(); step();
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) step();
    vectors++; if (n_md - m0 != 0 || n_ab - a0 != 0) begin miscompares++; $display("FAIL mid_no_pulse got=%0d/%0d exp=0/0", n_md - m0, n_ab - a0); end
    send_msg(2, 1, 8'h96, 8'h00, 8'h00, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL mid_fresh_timeout got=no_msg_done exp=msg_done"); end
    vectors++; if (gnt_seq[g0+1] !== 4'b0100) begin miscompares++; $display("FAIL mid_fresh_gnt got=%b exp=0100", gnt_seq[g0+1]); end
    vectors++; if (strt_dat[s0+1] !== 8'h96) begin miscompares++; $display("FAIL mid_fresh_data got=%h exp=96", strt_dat[s0+1]); end
    step(); step();
  endtask

  task automatic test_stuck_done();
    int s0, m0;
    bit ok;
    s0 = n_strt; m0 = n_md;
    stuck = 1'b1;
    send_msg(1, 1, 8'hE1, 8'h00, 8'h00, ok);
    stuck = 1'b0;
    step(); step();
    vectors++; if (!ok) begin miscompares++; $display("FAIL stuck_timeout got=no_msg_done exp=msg_done"); end
    vectors++; if (n_strt - s0 != 2) begin miscompares++; $display("FAIL stuck_strt_cnt got=%0d exp=2", n_strt - s0); end
    vectors++; if (strt_cyc[s0+1] - strt_cyc[s0] != 3) begin miscompares++; $display("FAIL stuck_retry_gap got=%0d exp=3", strt_cyc[s0+1] - strt_cyc[s0]); end
    vectors++; if (strt_dat[s0+1] !== 8'hE1) begin miscompares++; $display("FAIL stuck_retry_data got=%h exp=e1", strt_dat[s0+1]); end
  endtask

  initial begin
    bus.req       = '0;
    bus.byte_vld  = '0;
    bus.byte_last = '0;
    bus.byte_data = '0;
    test_reset();
    test_rr_order();
    test_single_msg();
    test_req_drop();
    test_timeout();
    test_reset_mid();
    test_stuck_done();
    vectors++; if (n_bad != 0) begin miscompares++; $display("FAIL strt_while_busy got=%0d exp=0", n_bad); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
